// File: rtl/pr_request_mq.sv
// pr_request_mq: multi-channel partial-reconfiguration request queue.
//   Per-channel FIFOs collect {ou_id, grid_slot} requests. Duplicate requests
//   can be coalesced. The oldest entry of a round-robin-selected channel is
//   exposed to the PR-management processor over AXI4-Lite.
// Ports:
//   clk, rst_n              clock (shared with AXI), synchronous active-low reset
//   push_valid/ready/data   per-channel request handshake, channel c at
//                           push_data[c*(OU_W+SLOT_W) +: OU_W+SLOT_W]
//   pr_request_pending      any channel non-empty
//   irq                     registered pr_request_pending & IRQ_EN
//   s_axi_*                 AXI4-Lite slave (STATUS, PEEK, POP, CTRL, COAL_CNT)
module pr_request_mq #(
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH        = 4,
    parameter int SLOT_W       = 4,
    parameter int OU_W         = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS-1:0]              push_valid,
    output logic [NUM_CHANNELS-1:0]              push_ready,
    input  logic [NUM_CHANNELS*(OU_W+SLOT_W)-1:0] push_data,
    output logic                                 pr_request_pending,
    output logic                                 irq,
    input  logic [4:0]                           s_axi_awaddr,
    input  logic                                 s_axi_awvalid,
    output logic                                 s_axi_awready,
    input  logic [31:0]                          s_axi_wdata,
    input  logic                                 s_axi_wvalid,
    output logic                                 s_axi_wready,
    output logic                                 s_axi_bvalid,
    input  logic                                 s_axi_bready,
    output logic [1:0]                           s_axi_bresp,
    input  logic [4:0]                           s_axi_araddr,
    input  logic                                 s_axi_arvalid,
    output logic                                 s_axi_arready,
    output logic [31:0]                          s_axi_rdata,
    output logic                                 s_axi_rvalid,
    input  logic                                 s_axi_rready,
    output logic [1:0]                           s_axi_rresp
);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int E_W   = OU_W + SLOT_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic       {W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_ADDR, R_CAPTURE, R_DATA} rstate_t;

    logic [E_W-1:0]   mem    [NUM_CHANNELS][DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_CHANNELS];
    logic [PTR_W-1:0] rd_ptr [NUM_CHANNELS];
    logic [CNT_W-1:0] cnt    [NUM_CHANNELS];
    logic [CH_W-1:0]  rr_ptr;

    logic [NUM_CHANNELS-1:0] nonempty, full, coal_hit, push_store, pop_sel;
    logic [15:0]             total;
    logic                    sel_valid;
    logic [CH_W-1:0]         sel_ch;
    logic [31:0]             status_word, peek_word, rd_mux;

    logic        irq_en, coal_en;
    logic [15:0] coal_cnt;
    logic [4:0]  coal_inc;
    logic [16:0] coal_sum;

    wstate_t     wstate, wnext;
    logic        aw_ack, wr_commit, flush_now, coal_clr;
    logic [4:0]  waddr_q;
    logic        wd_irq, wd_coal, wd_flush;

    rstate_t     rstate, rnext;
    logic        capture;
    logic [4:0]  raddr_q;
    logic [31:0] rdata_q;
    logic        pop_pend, pop_now;
    logic [CH_W-1:0] pop_ch;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, s_axi_wdata[30:2], 1'b0};

    assign s_axi_bresp = '0;
    assign s_axi_rresp = '0;
    assign s_axi_rdata = rdata_q;
    assign pr_request_pending = |nonempty;
    // A pop captured before a flush must not touch the post-flush FIFOs.
    assign pop_now = pop_pend && !flush_now;

    always_comb begin
        total = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            nonempty[c]   = (cnt[c] != '0);
            full[c]       = (cnt[c] == CNT_W'(DEPTH));
            push_ready[c] = !full[c] && !flush_now;
            total         = total + 16'(cnt[c]);
        end
    end

    // Duplicate detection: slot i is live when its distance from the head is below cnt.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs     = '0;
        coal_hit = '0;
        coal_inc = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                offs = PTR_W'(i) - rd_ptr[c];
                if (CNT_W'(offs) < cnt[c] && mem[c][i] == push_data[c*E_W +: E_W])
                    coal_hit[c] = 1'b1;
            end
            coal_hit[c]   = coal_hit[c] && coal_en;
            push_store[c] = push_valid[c] && push_ready[c] && !coal_hit[c];
            pop_sel[c]    = pop_now && (pop_ch == CH_W'(c));
            if (push_valid[c] && push_ready[c] && coal_hit[c])
                coal_inc = coal_inc + 5'd1;
        end
        coal_sum = {1'b0, coal_cnt} + 17'(coal_inc);
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_CHANNELS.
    always_comb begin
        logic [CH_W:0] idx;
        idx       = '0;
        sel_valid = 1'b0;
        sel_ch    = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CHANNELS))
                idx = idx - (CH_W+1)'(NUM_CHANNELS);
            if (!sel_valid && nonempty[idx[CH_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_ch    = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[NUM_CHANNELS-1:0] = nonempty;
        status_word[31:16] = total;
        peek_word = '0;
        if (sel_valid) begin
            peek_word[31] = 1'b1;
            peek_word[CH_W+E_W-1:0] = {sel_ch, mem[sel_ch][rd_ptr[sel_ch]]};
        end
        case (raddr_q)
            5'h00:   rd_mux = status_word;
            5'h04,
            5'h08:   rd_mux = peek_word;
            5'h0C:   rd_mux = {30'b0, coal_en, irq_en};
            5'h10:   rd_mux = {16'b0, coal_cnt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++)
            if (push_store[c] && !flush_now)
                mem[c][wr_ptr[c]] <= push_data[c*E_W +: E_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_now) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (push_store[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_sel[c])    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                case ({push_store[c], pop_sel[c]})
                    2'b10:   cnt[c] <= cnt[c] + 1'b1;
                    2'b01:   cnt[c] <= cnt[c] - 1'b1;
                    default: cnt[c] <= cnt[c];
                endcase
            end
            if (pop_now)
                rr_ptr <= (pop_ch == CH_W'(NUM_CHANNELS-1)) ? '0 : pop_ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            coal_en  <= 1'b0;
            coal_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_commit && waddr_q == 5'h0C) begin
                irq_en  <= wd_irq;
                coal_en <= wd_coal;
            end
            if (coal_clr)
                coal_cnt <= '0;
            else
                coal_cnt <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
            irq <= pr_request_pending && irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate   <= W_ADDR;
            aw_ack   <= 1'b0;
            waddr_q  <= '0;
            wd_irq   <= 1'b0;
            wd_coal  <= 1'b0;
            wd_flush <= 1'b0;
        end else begin
            wstate <= wnext;
            aw_ack <= (wstate == W_ADDR) && !aw_ack && s_axi_awvalid && s_axi_wvalid;
            if ((wstate == W_ADDR) && !aw_ack && s_axi_awvalid && s_axi_wvalid) begin
                waddr_q  <= s_axi_awaddr;
                wd_irq   <= s_axi_wdata[0];
                wd_coal  <= s_axi_wdata[1];
                wd_flush <= s_axi_wdata[31];
            end
        end
    end

    always_comb begin
        wnext         = wstate;
        wr_commit     = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate)
            W_ADDR: begin
                if (aw_ack) begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    wr_commit     = 1'b1;
                    wnext         = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wnext = W_ADDR;
            end
            default: wnext = W_ADDR;
        endcase
        flush_now = wr_commit && waddr_q == 5'h0C && wd_flush;
        coal_clr  = wr_commit && waddr_q == 5'h10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate   <= R_ADDR;
            raddr_q  <= '0;
            rdata_q  <= '0;
            pop_pend <= 1'b0;
            pop_ch   <= '0;
        end else begin
            rstate   <= rnext;
            pop_pend <= 1'b0;
            if (rstate == R_ADDR && s_axi_arvalid)
                raddr_q <= s_axi_araddr;
            if (capture) begin
                rdata_q  <= rd_mux;
                pop_pend <= (raddr_q == 5'h08) && sel_valid && !flush_now;
                pop_ch   <= sel_ch;
            end
        end
    end

    always_comb begin
        rnext         = rstate;
        capture       = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rstate)
            R_ADDR:    if (s_axi_arvalid) rnext = R_CAPTURE;
            R_CAPTURE: begin
                s_axi_arready = 1'b1;
                capture       = 1'b1;
                rnext         = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rnext = R_ADDR;
            end
            default: rnext = R_ADDR;
        endcase
    end
endmodule

// File: tb/tb_pr_request_mq.sv
module tb_pr_request_mq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  push_valid, push_ready;
    logic [11:0] push_data;
    logic        pr_request_pending, irq;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        pend;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pr_request_mq #(.NUM_CHANNELS(2), .DEPTH(4), .SLOT_W(4), .OU_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pr_request_pending(pr_request_pending), .irq(irq),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rresp(rresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [5:0] d);
        @(posedge clk); #1;
        push_data[c*6 +: 6] = d;
        push_valid[c] = 1'b1;
        @(posedge clk); #1;
        push_valid[c] = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] exp,
                            input int hold, output logic pend_rv);
        int n;
        logic got;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++; got = arready;
        end
        chk({tag, "_arready_lat"}, 32'(n), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0; got = rvalid;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++; got = rvalid;
        end
        chk({tag, "_rvalid_lat"}, 32'(n), 32'd0);
        pend_rv = pr_request_pending;
        chk(tag, rdata, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_hold_rdata"}, rdata, exp);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        int n;
        logic got;
        @(posedge clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++; got = awready && wready;
        end
        chk({tag, "_awready_lat"}, 32'(n), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0; got = bvalid;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++; got = bvalid;
        end
        chk({tag, "_bvalid_lat"}, 32'(n), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; push_valid = '0; push_data = '0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_push_ready", 32'(push_ready), 32'h3);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pending", 32'(pr_request_pending), 32'h0);
        chk("rst_handshakes", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        axi_read("status_reset", 5'h00, 32'h0, 0, pend);

        // ch0 {ou=1,slot=3} -> 0x13 ; ch1 {ou=2,slot=5} -> 0x25
        push(0, 6'h13);
        chk("push_pending", 32'(pr_request_pending), 32'h1);
        push(1, 6'h25);
        chk("irq_disabled", 32'(irq), 32'h0);
        axi_read("status_two", 5'h00, 32'h0002_0003, 0, pend);
        axi_read("peek_ch0", 5'h04, 32'h8000_0013, 0, pend);
        axi_read("pop_ch0", 5'h08, 32'h8000_0013, 0, pend);
        chk("pending_after_pop1", 32'(pr_request_pending), 32'h1);
        axi_read("pop_ch1", 5'h08, 32'h8000_0065, 0, pend);
        chk("pop_not_before_t3", 32'(pend), 32'h1);
        chk("pending_after_pop2", 32'(pr_request_pending), 32'h0);
        axi_read("pop_empty", 5'h08, 32'h0, 0, pend);

        // Fill ch1 with push_valid held high
        @(posedge clk); #1;
        push_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_data[6 +: 6] = 6'(k + 1);
            @(posedge clk); #1;
        end
        push_data[6 +: 6] = 6'h05;
        chk("full_ready", 32'(push_ready), 32'h1);
        axi_read("status_full", 5'h00, 32'h0004_0002, 0, pend);
        axi_read("pop_full", 5'h08, 32'h8000_0041, 0, pend);
        @(posedge clk); #1;
        push_valid[1] = 1'b0;
        chk("refull_ready", 32'(push_ready), 32'h1);
        axi_read("status_refull", 5'h00, 32'h0004_0002, 0, pend);
        for (int k = 2; k <= 5; k++)
            axi_read("drain_ch1", 5'h08, 32'h8000_0040 | 32'(k), 0, pend);

        // Coalescing
        axi_write("ctrl_coal", 5'h0C, 32'h2);
        axi_read("ctrl_rd", 5'h0C, 32'h2, 0, pend);
        push(0, 6'h13);
        push(0, 6'h13);
        axi_read("status_coal", 5'h00, 32'h0001_0001, 0, pend);
        axi_read("coal_cnt", 5'h10, 32'h1, 0, pend);
        axi_write("coal_clr", 5'h10, 32'h0);
        axi_read("coal_cnt_clr", 5'h10, 32'h0, 0, pend);
        axi_read("pop_coal", 5'h08, 32'h8000_0013, 0, pend);

        // Interrupt and flush
        axi_write("ctrl_irq", 5'h0C, 32'h1);
        push(0, 6'h13);
        push(1, 6'h25);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'h1);
        awaddr = 5'h0C; wdata = 32'h8000_0001; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        chk("flush_awready", 32'(awready), 32'h1);
        push_data[0 +: 6] = 6'h0A;
        push_valid[0] = 1'b1;
        chk("flush_push_refused", 32'(push_ready), 32'h0);
        @(posedge clk); #1;
        push_valid[0] = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("flush_bvalid", 32'(bvalid), 32'h1);
        chk("flush_pending", 32'(pr_request_pending), 32'h0);
        @(posedge clk); #1;
        chk("flush_irq_drop", 32'(irq), 32'h0);
        axi_read("status_flushed", 5'h00, 32'h0, 0, pend);
        axi_read("ctrl_after_flush", 5'h0C, 32'h1, 0, pend);

        // Slow rready; rr_ptr back at 0 after flush so ch0 wins
        push(1, 6'h25);
        push(0, 6'h13);
        axi_read("pop_slow", 5'h08, 32'h8000_0013, 5, pend);
        axi_read("status_slow", 5'h00, 32'h0001_0002, 0, pend);
        axi_read("pop_last", 5'h08, 32'h8000_0065, 0, pend);
        axi_read("status_end", 5'h00, 32'h0, 0, pend);
        axi_read("unmapped", 5'h14, 32'h0, 0, pend);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
